svo_axis_video_sink: RTL

- Receiving end of the pixel stream produced by the text/graphics test-card source (tvalid/tready/tdata, tuser[0] = start of frame).
- Generates raster timing (hcnt/vcnt, hsync/vsync/de) and pulls pixels only during active video.
- Aligns each stream start-of-frame to raster origin; recovers automatically from underflow or misalignment.
- Output feeds the TMDS/HDMI encoder.

---
 rtl/svo_timing_pkg.sv | 28 ++
 rtl/svo_raster_counter.sv | 56 +++++
 rtl/svo_axis_video_sink.sv | 122 ++++++++++++
 3 files changed

// File: rtl/svo_timing_pkg.sv
// rtl/svo_timing_pkg.sv - shared video timing defaults, derived totals and sink state enum
// Purpose: single source of raster timing defaults for the sink and the encoder.
package svo_timing_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEF_BITS_PER_PIXEL = 24;
  localparam int DEF_H_ACTIVE       = 640;
  localparam int DEF_H_FP           = 16;
  localparam int DEF_H_SYNC         = 96;
  localparam int DEF_H_BP           = 48;
  localparam int DEF_V_ACTIVE       = 480;
  localparam int DEF_V_FP           = 10;
  localparam int DEF_V_SYNC         = 2;
  localparam int DEF_V_BP           = 33;
  localparam int DEF_SYNC_POL       = 0;

  localparam int HT = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int VT = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Raster counter width; covers totals up to 4096 in either direction.
  localparam int CNT_W = 12;

endpackage

// File: rtl/svo_raster_counter.sv
// rtl/svo_raster_counter.sv - free-running hcnt/vcnt raster counter with timing decodes
// Ports:
//   clk, resetn         pixel clock, synchronous active-low reset
//   active              hcnt/vcnt inside the visible area
//   origin              first pixel of the frame (hcnt == 0, vcnt == 0)
//   hs_on, vs_on        inside the horizontal / vertical sync pulse
module svo_raster_counter
  import svo_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic resetn,
  output logic active,
  output logic origin,
  output logic hs_on,
  output logic vs_on
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign origin = (hcnt == '0) && (vcnt == '0);
  assign hs_on  = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_on  = (vcnt >= VS_START) && (vcnt < VS_END);

endmodule

// File: rtl/svo_axis_video_sink.sv
// rtl/svo_axis_video_sink.sv - stream-to-raster video sink with SOF alignment and auto-recovery
// Ports:
//   clk, resetn                          pixel clock, synchronous active-low reset
//   in_axis_tvalid/tready/tdata/tuser    pixel stream in, tuser = start of frame
//   vid_rgb, vid_de, vid_hsync, vid_vsync registered raster out (latency 1 from counters)
//   locked                               sink is streaming (RUN)
//   underflow, resync                    one-cycle error pulses, aligned with vid_*
module svo_axis_video_sink
  import svo_timing_pkg::*;
#(
  parameter int SVO_BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
  parameter int H_ACTIVE           = DEF_H_ACTIVE,
  parameter int H_FP               = DEF_H_FP,
  parameter int H_SYNC             = DEF_H_SYNC,
  parameter int H_BP               = DEF_H_BP,
  parameter int V_ACTIVE           = DEF_V_ACTIVE,
  parameter int V_FP               = DEF_V_FP,
  parameter int V_SYNC             = DEF_V_SYNC,
  parameter int V_BP               = DEF_V_BP,
  parameter int SYNC_POL           = DEF_SYNC_POL
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                          in_axis_tuser,
  output logic [SVO_BITS_PER_PIXEL-1:0] vid_rgb,
  output logic                          vid_de,
  output logic                          vid_hsync,
  output logic                          vid_vsync,
  output logic                          locked,
  output logic                          underflow,
  output logic                          resync
);

  localparam logic SYNC_LVL = (SYNC_POL != 0);

  logic   active, origin, hs_on, vs_on;
  state_t state, state_nxt;
  logic   disp;
  logic   underflow_nxt, resync_nxt;

  svo_raster_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .active (active),
    .origin (origin),
    .hs_on  (hs_on),
    .vs_on  (vs_on)
  );

  // disp marks a pixel that is both consumed and shown this cycle; it is only
  // ever set inside active video, so it doubles as the data enable.
  always_comb begin
    state_nxt      = state;
    in_axis_tready = 1'b0;
    disp           = 1'b0;
    underflow_nxt  = 1'b0;
    resync_nxt     = 1'b0;
    case (state)
      HUNT: begin
        // Drain stale pixels but leave the SOF pixel waiting for the origin.
        in_axis_tready = !(in_axis_tvalid && in_axis_tuser);
        if (in_axis_tvalid && in_axis_tuser) state_nxt = HOLD;
      end
      HOLD: begin
        in_axis_tready = origin;
        if (origin && in_axis_tvalid) begin
          disp      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_axis_tready = active && !(in_axis_tvalid && in_axis_tuser && !origin);
        // Underflow first: with tvalid low, tuser carries no meaning.
        if (active && !in_axis_tvalid) begin
          underflow_nxt = 1'b1;
          state_nxt     = HUNT;
        end else if (active && in_axis_tuser && !origin) begin
          // Early SOF: keep it in the stream and show it at the next origin.
          resync_nxt = 1'b1;
          state_nxt  = HOLD;
        end else if (origin && !in_axis_tuser) begin
          // Missing SOF: the pixel is already here, so show it, then re-hunt.
          disp       = 1'b1;
          resync_nxt = 1'b1;
          state_nxt  = HUNT;
        end else if (active) begin
          disp = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= HUNT;
      vid_rgb   <= '0;
      vid_de    <= 1'b0;
      vid_hsync <= !SYNC_LVL;
      vid_vsync <= !SYNC_LVL;
      underflow <= 1'b0;
      resync    <= 1'b0;
    end else begin
      state     <= state_nxt;
      vid_rgb   <= disp ? in_axis_tdata : '0;
      vid_de    <= disp;
      vid_hsync <= hs_on ? SYNC_LVL : !SYNC_LVL;
      vid_vsync <= vs_on ? SYNC_LVL : !SYNC_LVL;
      underflow <= underflow_nxt;
      resync    <= resync_nxt;
    end
  end

  assign locked = (state == RUN);

endmodule
